// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Contents: the sequencer state enum, the channel/data widths, the averaging
// constants and a lowest-set-bit helper used to pick the next channel.
package adc_seq_pkg;

  localparam int unsigned ADC_CH_OFFSET = 1;   // logical index i -> ADC channel i+1
  localparam int unsigned NUM_LCH       = 8;   // logical channels per scan
  localparam int unsigned ADC_DW        = 12;  // conversion result width
  localparam int unsigned CH_W          = 5;   // ADC channel number width
  localparam int unsigned IDX_W         = 3;   // logical channel index width
  localparam int unsigned NUM_AVG       = 4;   // conversions per channel when averaging
  localparam int unsigned ACC_W         = 14;  // sum of NUM_AVG results

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    ISSUE,
    WAIT_RSP,
    STORE
  } seq_state_e;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_LCH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_LCH) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_seq_ticker.sv
// Free-running scan-rate divider: counts 0..SCAN_DIV-1 and emits a one-cycle
// tick on wrap, independent of whether scanning is enabled.
// Ports:
//   Clk      in   system clock
//   Reset_h  in   synchronous active-high reset (zeroes the counter)
//   tick     out  one-cycle pulse per SCAN_DIV clocks
module adc_seq_ticker #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic Clk,
  input  logic Reset_h,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter with registered wrap strobe.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_LAST);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic scan sequencer for the modular ADC. On each scan tick (when enabled)
// the channel mask is latched and every selected logical channel is converted
// in ascending order over the Avalon-ST command/response interface; results
// land in an 8-entry bank readable through rd_sel/rd_data.
// Build option: define ADC_SEQ_AVG_EN to convert each channel 4 times and
// store the 14-bit sum divided by 4; otherwise one conversion is stored as-is.
// Ports:
//   Clk, Reset_h            clock, synchronous active-high reset
//   enable, ch_mask         scan enable level, logical channel select
//   cmd_valid/channel/sop/eop, cmd_ready   command stream to the ADC
//   rsp_valid/channel/data  response stream from the ADC
//   rd_sel, rd_data         result bank read port (registered)
//   scan_done               pulse after the last channel of a scan is stored
//   overrun, err, err_clr   sticky status flags and their clear
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input  logic               Clk,
  input  logic               Reset_h,
  input  logic               enable,
  input  logic [NUM_LCH-1:0] ch_mask,
  output logic               cmd_valid,
  output logic [CH_W-1:0]    cmd_channel,
  output logic               cmd_sop,
  output logic               cmd_eop,
  input  logic               cmd_ready,
  input  logic               rsp_valid,
  input  logic [CH_W-1:0]    rsp_channel,
  input  logic [ADC_DW-1:0]  rsp_data,
  input  logic [IDX_W-1:0]   rd_sel,
  output logic [ADC_DW-1:0]  rd_data,
  output logic               scan_done,
  output logic               overrun,
  output logic               err,
  input  logic               err_clr
);

  localparam int unsigned TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);

  seq_state_e         state, state_d;
  logic               tick;
  logic [NUM_LCH-1:0] scan_mask;
  logic [NUM_LCH-1:0] done_mask;
  logic [NUM_LCH-1:0] pending;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ADC_DW-1:0]  sample;
  logic [ADC_DW-1:0]  sample_d;
  logic [ADC_DW-1:0]  result [NUM_LCH];
  logic               last_conv;

  logic start_c, pick_c, finish_c, accept_c, rsp_hit_c, rsp_bad_c, timeout_c;

  adc_seq_ticker #(.SCAN_DIV(SCAN_DIV)) u_ticker (
    .Clk    (Clk),
    .Reset_h(Reset_h),
    .tick   (tick)
  );

  assign cmd_sop  = cmd_valid;
  assign cmd_eop  = cmd_valid;
  assign pending  = scan_mask & ~done_mask;
  assign pick_idx = lowest_set(pending);

`ifdef ADC_SEQ_AVG_EN
  logic [1:0]       conv_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum   = acc + ACC_W'(rsp_data);
  assign last_conv = (conv_cnt == 2'(NUM_AVG - 1));
  assign sample_d  = acc_sum[ACC_W-1:2];

  // Accumulator restarts per channel; a timeout abandons the partial sum
  // because the next PICK clears it.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      conv_cnt <= '0;
      acc      <= '0;
    end else if (pick_c) begin
      conv_cnt <= '0;
      acc      <= '0;
    end else if (rsp_hit_c) begin
      conv_cnt <= conv_cnt + 2'd1;
      acc      <= acc_sum;
    end
  end
`else
  assign last_conv = 1'b1;
  assign sample_d  = rsp_data;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset_h) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d   = state;
    start_c   = 1'b0;
    pick_c    = 1'b0;
    finish_c  = 1'b0;
    accept_c  = 1'b0;
    rsp_hit_c = 1'b0;
    rsp_bad_c = 1'b0;
    timeout_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && enable && (ch_mask != '0)) begin
          start_c = 1'b1;
          state_d = PICK;
        end
      end
      PICK: begin
        if (pending != '0) begin
          pick_c  = 1'b1;
          state_d = ISSUE;
        end else begin
          finish_c = 1'b1;
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c = 1'b1;
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid && (rsp_channel == cmd_channel)) begin
          rsp_hit_c = 1'b1;
          state_d   = last_conv ? STORE : ISSUE;
        end else begin
          rsp_bad_c = rsp_valid;
          if (tmo_cnt == TMO_LAST) begin
            timeout_c = 1'b1;
            state_d   = PICK;
          end
        end
      end
      STORE:   state_d = PICK;
      default: state_d = IDLE;
    endcase
  end

  // Scan bookkeeping, command outputs, result bank and status flags.
  // The channel is marked done at selection, so a timeout simply moves on.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      scan_mask   <= '0;
      done_mask   <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      sample      <= '0;
      cmd_valid   <= 1'b0;
      cmd_channel <= '0;
      scan_done   <= 1'b0;
      rd_data     <= '0;
      err         <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < NUM_LCH; i++) result[i] <= '0;
    end else begin
      cmd_valid <= (state_d == ISSUE);
      scan_done <= finish_c;
      tmo_cnt   <= (state == WAIT_RSP) ? tmo_cnt + TMO_W'(1) : '0;

      if (start_c) begin
        scan_mask <= ch_mask;
        done_mask <= '0;
      end
      if (pick_c) begin
        idx                 <= pick_idx;
        done_mask[pick_idx] <= 1'b1;
        cmd_channel         <= CH_W'(pick_idx) + CH_W'(ADC_CH_OFFSET);
      end
      if (rsp_hit_c) sample <= sample_d;
      if (state == STORE) result[idx] <= sample;

      // Bypass the bank write so rd_data shows a fresh store one cycle later.
      rd_data <= ((state == STORE) && (rd_sel == idx)) ? sample : result[rd_sel];

      if (err_clr)                       err <= 1'b0;
      else if (rsp_bad_c || timeout_c)   err <= 1'b1;

      if (err_clr)                       overrun <= 1'b0;
      else if (tick && (state != IDLE))  overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer with a behavioural modular-ADC model.
module tb_adc_scan_sequencer;

  localparam int unsigned SD  = 150;
  localparam int unsigned TMO = 40;
`ifdef ADC_SEQ_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic        Clk;
  logic        Reset_h, enable, cmd_ready, rsp_valid, err_clr;
  logic [7:0]  ch_mask;
  logic [4:0]  rsp_channel, cmd_channel;
  logic [11:0] rsp_data, rd_data;
  logic [2:0]  rd_sel;
  logic        cmd_valid, cmd_sop, cmd_eop, scan_done, overrun, err;

  adc_scan_sequencer #(.SCAN_DIV(SD), .RSP_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .enable(enable), .ch_mask(ch_mask),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop),
    .cmd_eop(cmd_eop), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_channel(rsp_channel), .rsp_data(rsp_data), .rd_sel(rd_sel),
    .rd_data(rd_data), .scan_done(scan_done), .overrun(overrun), .err(err),
    .err_clr(err_clr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int cmd_cnt  = 0;
  logic [4:0] exp_cmd [$];

  // ADC model controls
  int          lat = 3;
  logic [7:0]  norsp = '0;
  int          hold_left = 0;
  bit          wrong_first = 1'b0;
  logic [11:0] tab [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_to(input string name, input int budget);
    n_checks++;
    $display("FAIL %s: no event within %0d cycles, expected one", name, budget);
  endtask

  // Expected stored value for a channel whose base sample is v.
  function automatic logic [11:0] stored(input logic [11:0] v);
    if (NCONV == 4) return 12'((4 * int'(v) + 6) >> 2);
    else            return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
    #2;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int i;
    for (i = 0; i < budget && done_cnt <= base; i++) cycles(1);
    if (done_cnt <= base) fail_to(name, budget);
  endtask

  task automatic wait_cmd(input int base, input int budget, input string name);
    int i;
    for (i = 0; i < budget && cmd_cnt <= base; i++) cycles(1);
    if (cmd_cnt <= base) fail_to(name, budget);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !cmd_valid; i++) cycles(1);
    if (!cmd_valid) fail_to(name, budget);
  endtask

  task automatic check_rd(input logic [2:0] idx, input logic [11:0] exp, input string name);
    rd_sel = idx;
    cycles(1);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    cycles(1);
  endtask

  task automatic push_ch(input logic [4:0] ch, input int n);
    for (int k = 0; k < n; k++) exp_cmd.push_back(ch);
  endtask

  // ADC model: drives ready/responses on the falling edge.
  initial begin
    int         pend;
    int         conv_k;
    logic [4:0] pch;
    logic [2:0] li;
    pend = 0; conv_k = 0; pch = '0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
    forever begin
      @(negedge Clk);
      rsp_valid = 1'b0;
      if (Reset_h) begin
        pend = 0;
        conv_k = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rsp_valid = 1'b1;
          if (wrong_first) begin
            rsp_channel = pch + 5'd1;
            rsp_data    = '0;
            wrong_first = 1'b0;
            pend        = 2;
          end else begin
            rsp_channel = pch;
            rsp_data    = tab[pch] + 12'(conv_k);
            conv_k      = (conv_k + 1) % NCONV;
          end
        end
      end
      if (cmd_valid && hold_left > 0) begin
        cmd_ready = 1'b0;
        hold_left--;
      end else begin
        cmd_ready = 1'b1;
      end
      if (!Reset_h && cmd_valid && cmd_ready) begin
        li = 3'(cmd_channel - 5'd1);
        if (!norsp[li]) begin
          pend = lat;
          pch  = cmd_channel;
        end
      end
    end
  end

  // Monitor: pops the expected command on every accepted handshake.
  initial begin
    forever begin
      @(negedge Clk);
      #1;
      if (!Reset_h) begin
        if (scan_done) done_cnt++;
        if (cmd_valid && cmd_ready) begin
          cmd_cnt++;
          chk("cmd_sop_eop", 32'({cmd_sop, cmd_eop}), 32'd3);
          if (exp_cmd.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_cmd: got channel %0d, expected no command", cmd_channel);
          end else begin
            chk("cmd_channel", 32'(cmd_channel), 32'(exp_cmd.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0, c0;
    bit  stable;
    Reset_h = 1'b1; enable = 1'b0; ch_mask = '0; err_clr = 1'b0; rd_sel = '0;
    for (int c = 0; c < 32; c++) tab[c] = 12'(c * 'h111);
    cycles(5);
    Reset_h = 1'b0;

    // reset state
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rd_data", 32'(rd_data), 0);

    // single channel, two scans
    tab[1] = 12'hABC;
    push_ch(5'd1, 2 * NCONV);
    d0 = done_cnt;
    ch_mask = 8'h01; enable = 1'b1;
    wait_done(d0, 2 * SD + 200, "t1_first_done");
    check_rd(3'd0, stored(12'hABC), "t1_result0");
    wait_done(d0 + 1, 2 * SD + 200, "t1_second_done");
    enable = 1'b0;
    cycles(SD + 20);
    chk("t1_done_count", 32'(done_cnt - d0), 2);
    chk("t1_cmds_left", 32'(exp_cmd.size()), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_overrun", 32'(overrun), 0);

    // ordering 0xA5; mask change and enable drop mid-scan
    tab[1] = 12'h111;
    push_ch(5'd1, NCONV); push_ch(5'd3, NCONV); push_ch(5'd6, NCONV); push_ch(5'd8, NCONV);
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'hA5; enable = 1'b1;
    wait_cmd(c0, 2 * SD, "t2_start");
    enable = 1'b0; ch_mask = 8'h02;
    wait_done(d0, 2 * SD + 400, "t2_done");
    cycles(5);
    chk("t2_done_count", 32'(done_cnt - d0), 1);
    chk("t2_cmd_count", 32'(cmd_cnt - c0), 32'(4 * NCONV));
    chk("t2_cmds_left", 32'(exp_cmd.size()), 0);
    for (int i = 0; i < 8; i++)
      check_rd(3'(i), ((8'hA5 >> i) & 8'h01) != 0 ? stored(tab[i + 1]) : 12'h000, "t2_result");

    // channel mismatch sets err, correct response still stored
    push_ch(5'd5, NCONV);
    wrong_first = 1'b1;
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'h10; enable = 1'b1;
    wait_cmd(c0, 2 * SD, "t3_start");
    enable = 1'b0;
    wait_done(d0, SD + 200, "t3_done");
    chk("t3_err_set", 32'(err), 1);
    check_rd(3'd4, stored(tab[5]), "t3_result4");
    pulse_clr();
    chk("t3_err_clr", 32'(err), 0);

    // backpressure on ch1, ch1 never answers, ch2 still converted
    push_ch(5'd1, 1); push_ch(5'd2, NCONV);
    norsp = 8'h01; hold_left = 10;
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'h03; enable = 1'b1;
    wait_valid(2 * SD, "t4_valid");
    stable = cmd_valid && (cmd_channel == 5'd1) && !cmd_ready;
    for (int i = 0; i < 9; i++) begin
      cycles(1);
      stable &= cmd_valid && (cmd_channel == 5'd1) && !cmd_ready;
    end
    enable = 1'b0;
    chk("t4_cmd_stable", 32'(stable), 1);
    wait_cmd(c0, 20, "t4_accept");
    cycles(TMO - 2);
    chk("t4_err_before_timeout", 32'(err), 0);
    cycles(4);
    chk("t4_err_after_timeout", 32'(err), 1);
    wait_done(d0, SD + 200, "t4_done");
    norsp = '0;
    check_rd(3'd0, stored(12'h111), "t4_result0_kept");
    check_rd(3'd1, stored(tab[2]), "t4_result1");
    chk("t4_cmds_left", 32'(exp_cmd.size()), 0);
    chk("t4_overrun", 32'(overrun), 0);
    pulse_clr();

    // long scan overruns the tick
    lat = 30;
    for (int c = 1; c <= 8; c++) push_ch(5'(c), NCONV);
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'hFF; enable = 1'b1;
    wait_cmd(c0, 2 * SD, "t5_start");
    enable = 1'b0;
    wait_done(d0, 8 * NCONV * 40 + 2 * SD, "t5_done");
    chk("t5_overrun_set", 32'(overrun), 1);
    chk("t5_err", 32'(err), 0);
    for (int i = 0; i < 8; i++) check_rd(3'(i), stored(tab[i + 1]), "t5_result");
    pulse_clr();
    chk("t5_overrun_clr", 32'(overrun), 0);
    lat = 3;

    // empty mask: no commands, no scan_done over 3 ticks
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'h00; enable = 1'b1;
    cycles(3 * SD + 10);
    enable = 1'b0;
    chk("t6_no_cmds", 32'(cmd_cnt - c0), 0);
    chk("t6_no_done", 32'(done_cnt - d0), 0);

    // averaging value: 100..103 -> 101 when averaging, else 100
    tab[3] = 12'd100;
    push_ch(5'd3, NCONV);
    d0 = done_cnt; c0 = cmd_cnt;
    ch_mask = 8'h04; enable = 1'b1;
    wait_cmd(c0, 2 * SD, "t7_start");
    enable = 1'b0;
    wait_done(d0, SD + 200, "t7_done");
    check_rd(3'd2, stored(12'd100), "t7_avg_value");

    // reset while a command is held off
    hold_left = 1000;
    ch_mask = 8'h01; enable = 1'b1;
    wait_valid(2 * SD, "t8_valid");
    Reset_h = 1'b1;
    @(posedge Clk);
    #1;
    chk("t8_cmd_valid_dropped", 32'(cmd_valid), 0);
    chk("t8_scan_done", 32'(scan_done), 0);
    hold_left = 0; enable = 1'b0;
    cycles(2);
    Reset_h = 1'b0;
    c0 = cmd_cnt;
    for (int i = 0; i < 8; i++) check_rd(3'(i), 12'h000, "t8_result_cleared");
    chk("t8_err", 32'(err), 0);
    chk("t8_overrun", 32'(overrun), 0);
    cycles(SD + 20);
    chk("t8_no_cmds", 32'(cmd_cnt - c0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks between scan-start ticks (1 kHz at 50 MHz).
REQ-002 SHALL have parameter RSP_TIMEOUT, default 1023, max clocks waiting for a response.
REQ-003 SHALL have the following ports:
- Clk  in  1  system clock, MAX10_CLK1_50 domain; the only clock.
- Reset_h  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = periodic scanning allowed.
- ch_mask  in  8  logical channels to scan; bit i maps to ADC channel i+1.
- cmd_valid  out  1  Avalon-ST command valid to modular ADC.
- cmd_channel  out  5  ADC channel number.
- cmd_sop, cmd_eop  out  1 each  both driven equal to cmd_valid.
- cmd_ready  in  1  ADC accepts command when high with cmd_valid.
- rsp_valid  in  1  response strobe.
- rsp_channel  in  5  response channel.
- rsp_data  in  12  conversion result.
- rd_sel  in  3  result-bank read index.
- rd_data  out  12  registered result for rd_sel.
- scan_done  out  1  one-cycle pulse after the last channel of a scan is stored.
- overrun  out  1  sticky; a tick arrived while a scan was busy.
- err  out  1  sticky; timeout or channel mismatch.
- err_clr  in  1  clears overrun and err.

Function
REQ-004 SHALL run a free counter 0..SCAN_DIV-1 producing a one-cycle tick at wrap; the counter runs regardless of enable.
REQ-005 SHALL implement states IDLE, PICK, ISSUE, WAIT_RSP, STORE.
REQ-006 IDLE: on tick with enable=1 and ch_mask!=0, SHALL latch ch_mask into scan_mask and go to PICK; with ch_mask==0, SHALL stay in IDLE and issue no command.
REQ-007 PICK: SHALL select the lowest set bit of scan_mask not yet done; if none remain, SHALL pulse scan_done and go to IDLE.
REQ-008 ISSUE: SHALL hold cmd_valid=1 with cmd_channel=index+1, stable until cmd_ready=1; on the accepting cycle SHALL deassert next cycle and go to WAIT_RSP.
REQ-009 WAIT_RSP: on rsp_valid with rsp_channel equal to the issued channel, SHALL go to STORE; on a mismatching rsp_channel, SHALL set err and keep waiting.
REQ-010 WAIT_RSP: after RSP_TIMEOUT clocks with no matching response, SHALL set err, leave that result unchanged, mark the channel done and go to PICK.
REQ-011 STORE: SHALL write the sample into result[index] and go to PICK; rd_data SHALL reflect the write one cycle after STORE.
REQ-012 A tick outside IDLE SHALL be dropped and SHALL set overrun.
REQ-013 rsp_valid outside WAIT_RSP SHALL be ignored without flagging.
REQ-014 ch_mask changes during a scan SHALL take effect at the next scan only.
REQ-015 Deasserting enable mid-scan SHALL let the current scan complete.
REQ-016 err_clr SHALL take priority over a same-cycle set.

Reset
REQ-017 On Reset_h the block SHALL enter IDLE and zero the tick counter, scan_mask, all results, rd_data, err and overrun; cmd_valid and scan_done SHALL be 0 in the cycle after reset is sampled.
REQ-018 Reset mid-handshake SHALL drop cmd_valid with no further command; any late response SHALL be ignored per REQ-013.

Configuration
REQ-019 ADC_SEQ_AVG_EN defined: each channel SHALL be converted 4 times back-to-back (ISSUE/WAIT_RSP repeated), and the stored value SHALL be the 14-bit sum bits [13:2]; a timeout on any of the 4 conversions SHALL discard all 4.
REQ-020 ADC_SEQ_AVG_EN undefined: one conversion per channel, stored directly; no accumulator hardware.

Structure
REQ-021 Package adc_seq_pkg SHALL hold the state enum, ADC_CH_OFFSET=1, NUM_LCH=8, ADC_DW=12, CH_W=5.
REQ-022 Tick generation SHALL be the sub-module adc_seq_ticker (parameter SCAN_DIV, output tick).

Verification
REQ-023 Single channel: ch_mask=0x01, ADC model with ready=1 and a response 3 clks later with data 0xABC -> cmd_channel=1, result[0]=0xABC, one scan_done per tick.
REQ-024 Ordering: ch_mask=0xA5 -> commands on channels 1,3,6,8 in that order; exactly 4 stores; scan_done after the 4th.
REQ-025 Backpressure and timeout: cmd_ready held low 10 clks -> cmd_valid and channel stable throughout; model never responds -> err=1 after RSP_TIMEOUT clks, result unchanged, scan continues.
REQ-026 Overrun: SCAN_DIV=20 with response latency 30 -> overrun=1; err_clr -> overrun=0.
REQ-027 Edges: ch_mask=0 -> zero commands over 3 ticks; Reset_h during ISSUE -> cmd_valid=0 the next cycle and all results 0.
REQ-028 With ADC_SEQ_AVG_EN, responses 100,101,102,103 -> stored value 101.
